// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: FSM encodings, default abort timeout and byte-lane helper
// shared by the round-robin UART transmit arbiter.
package uart_tx_arbiter_pkg;

   localparam logic [1:0] ARB_IDLE  = 2'd0;
   localparam logic [1:0] ARB_START = 2'd1;
   localparam logic [1:0] ARB_WAIT  = 2'd2;

   localparam int BIT_CLKS    = 8;
   localparam int FRAME_BITS  = 10;
   // two full frame times before a silent transmitter is declared dead
   localparam int TIMEOUT_DEF = BIT_CLKS * FRAME_BITS * 2;

   function automatic logic [7:0] lane(input logic [63:0] v, input logic [2:0] i);
      return v[{i, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and transmitter handshake bundle around the arbiter;
// master is the arbiter side, slave the requester/transmitter side.
interface uart_tx_arbiter_if #(parameter int N_REQ = 4);

   logic [N_REQ-1:0]   req;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   ack;
   logic               busy;
   logic               tx_ready;
   logic [7:0]         tx_data_o;
   logic               tx_ok;
   logic [2:0]         last_gnt;
   logic               tx_err;

   modport master (
      input  req, req_data, tx_ok,
      output ack, busy, tx_ready, tx_data_o, last_gnt, tx_err
   );

   modport slave (
      output req, req_data, tx_ok,
      input  ack, busy, tx_ready, tx_data_o, last_gnt, tx_err
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_tx_arbiter_rr_pick: combinational rotate-priority encoder; the first set
// request after last_gnt (wrapping modulo N_REQ) wins.
module uart_tx_arbiter_rr_pick #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] req,
   input  logic [2:0]       last_gnt,
   output logic [2:0]       winner,
   output logic             valid
);

   logic [2*N_REQ-1:0] rot;
   logic [3:0]         off;
   logic [3:0]         sum;

   // doubling the vector makes the wrap-around a plain right shift
   always_comb begin
      rot = {req, req} >> (4'(last_gnt) + 4'd1);
      off = '0;
      for (int i = N_REQ - 1; i >= 0; i--)
         if (rot[i]) off = 4'(i);
      sum = 4'(last_gnt) + 4'd1 + off;
      valid = |req;
      winner = 3'(sum >= 4'(N_REQ) ? sum - 4'(N_REQ) : sum);
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmitter among N_REQ producers.
// Define UART_ARB_TIMEOUT_EN to abort frames whose tx_ok never arrives (tx_err pulse).
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
   input logic                sys_clk,
   input logic                rst_n,
   uart_tx_arbiter_if.master  bus
);

   logic [1:0]       state_q, state_d;
   logic [2:0]       last_gnt_q, last_gnt_d;
   logic [7:0]       data_q, data_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic             busy_q, busy_d;
   logic             tx_ready_q, tx_ready_d;
   logic [2:0]       winner;
   logic             valid;
`ifdef UART_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             tx_err_q, tx_err_d;
`endif

   uart_tx_arbiter_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req      (bus.req),
      .last_gnt (last_gnt_q),
      .winner   (winner),
      .valid    (valid)
   );

   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      data_d     = data_q;
      ack_d      = '0;
      busy_d     = busy_q;
      tx_ready_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_d      = cnt_q;
      tx_err_d   = 1'b0;
`endif
      if (state_q == ARB_IDLE && valid) begin
         state_d    = ARB_START;
         last_gnt_d = winner;
         data_d     = lane(64'(bus.req_data), winner);
         ack_d      = N_REQ'(1) << winner;
         busy_d     = 1'b1;
      end
      // registered start pulse lands the cycle after ack
      if (state_q == ARB_START) begin
         state_d    = ARB_WAIT;
         tx_ready_d = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
         cnt_d      = '0;
`endif
      end
      if (state_q == ARB_WAIT) begin
         if (bus.tx_ok) begin
            state_d = ARB_IDLE;
            busy_d  = 1'b0;
         end
`ifdef UART_ARB_TIMEOUT_EN
         else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            state_d  = ARB_IDLE;
            busy_d   = 1'b0;
            tx_err_d = 1'b1;
         end
         else cnt_d = cnt_q + 1'b1;
`endif
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ARB_IDLE;
         last_gnt_q <= 3'(N_REQ - 1);
         data_q     <= 8'h00;
         ack_q      <= '0;
         busy_q     <= 1'b0;
         tx_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         data_q     <= data_d;
         ack_q      <= ack_d;
         busy_q     <= busy_d;
         tx_ready_q <= tx_ready_d;
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         tx_err_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         tx_err_q <= tx_err_d;
      end
   end
   assign bus.tx_err = tx_err_q;
`else
   assign bus.tx_err = 1'b0;
`endif

   assign bus.ack       = ack_q;
   assign bus.busy      = busy_q;
   assign bus.tx_ready  = tx_ready_q;
   assign bus.tx_data_o = data_q;
   assign bus.last_gnt  = last_gnt_q;

endmodule
